// File: rtl/tvc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : tvc_pkg                                                         |
// | Purpose  : Types and constants shared by the Triangles-vs-Circles stages   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package tvc_pkg;

  localparam int COORD_W_DEF = 4;
  localparam int GRID_N_DEF  = 10;

  typedef enum logic [2:0] {
    S_COLLECT_X   = 3'd0,
    S_COLLECT_Y   = 3'd1,
    S_ARMED       = 3'd2,
    S_OFFER       = 3'd3,
    S_WAIT_RESULT = 3'd4
  } entry_state_t;

  typedef enum logic {
    PLAYER_TRIANGLE = 1'b0,
    PLAYER_CIRCLE   = 1'b1
  } player_t;

  // On-screen prompt code; offer and wait share the "busy" prompt.
  function automatic logic [1:0] phase_of(input entry_state_t s);
    case (s)
      S_COLLECT_X: phase_of = 2'd0;
      S_COLLECT_Y: phase_of = 2'd1;
      S_ARMED:     phase_of = 2'd2;
      default:     phase_of = 2'd3;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : button_conditioner                                              |
// | Purpose  : 2-FF synchroniser, debouncer and rising-edge press pulse        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int                CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= i_btn;
      r_sync1   <= r_sync0;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (r_sync1 != r_level) begin
        if (r_cnt == c_LAST) begin
          r_level <= r_sync1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/move_entry_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : move_entry_controller                                           |
// | Purpose  : Serial X/Y move entry, valid/ready offer and turn tracking      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module move_entry_controller
  import tvc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COORD_W         = COORD_W_DEF,
  parameter int GRID_N          = GRID_N_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_logic0,
  input  logic                 btn_logic1,
  input  logic                 btn_activity,
  output logic                 move_valid,
  input  logic                 move_ready,
  output logic [COORD_W-1:0]   move_x,
  output logic [COORD_W-1:0]   move_y,
  output logic                 move_player,
  input  logic                 result_valid,
  input  logic                 result_ok,
  output logic [1:0]           entry_phase,
  output logic [2*COORD_W-1:0] entry_value,
  output logic                 move_accepted,
  output logic                 move_rejected
);

  localparam int                 CNT_W   = $clog2(COORD_W) + 1;
  localparam logic [CNT_W-1:0]   c_LAST  = CNT_W'(COORD_W - 1);
  localparam logic [COORD_W:0]   c_LIMIT = (COORD_W + 1)'(GRID_N);

  logic w_p0;
  logic w_p1;
  logic w_pa;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn0 (
    .clk(clk), .reset(reset), .i_btn(btn_logic0), .o_press(w_p0)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
    .clk(clk), .reset(reset), .i_btn(btn_logic1), .o_press(w_p1)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btna (
    .clk(clk), .reset(reset), .i_btn(btn_activity), .o_press(w_pa)
  );

  entry_state_t       r_state,  w_state_nxt;
  logic [COORD_W-1:0] r_x_sr,   w_x_nxt;
  logic [COORD_W-1:0] r_y_sr,   w_y_nxt;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
  logic [COORD_W-1:0] r_move_x, w_mx_nxt;
  logic [COORD_W-1:0] r_move_y, w_my_nxt;
  player_t            r_move_p, w_mp_nxt;
  player_t            r_player, w_player_nxt;
  logic               r_acc,    w_acc_nxt;
  logic               r_rej,    w_rej_nxt;

  // Simultaneous 0/1 presses are ambiguous and dropped; activity overrides bits.
  logic w_bit_valid;
  logic w_legal;
  assign w_bit_valid = (w_p0 ^ w_p1) & ~w_pa;
  assign w_legal     = ({1'b0, r_x_sr} < c_LIMIT) && ({1'b0, r_y_sr} < c_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_COLLECT_X;
      r_x_sr   <= '0;
      r_y_sr   <= '0;
      r_cnt    <= '0;
      r_move_x <= '0;
      r_move_y <= '0;
      r_move_p <= PLAYER_TRIANGLE;
      r_player <= PLAYER_TRIANGLE;
      r_acc    <= 1'b0;
      r_rej    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_x_sr   <= w_x_nxt;
      r_y_sr   <= w_y_nxt;
      r_cnt    <= w_cnt_nxt;
      r_move_x <= w_mx_nxt;
      r_move_y <= w_my_nxt;
      r_move_p <= w_mp_nxt;
      r_player <= w_player_nxt;
      r_acc    <= w_acc_nxt;
      r_rej    <= w_rej_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_x_nxt      = r_x_sr;
    w_y_nxt      = r_y_sr;
    w_cnt_nxt    = r_cnt;
    w_mx_nxt     = r_move_x;
    w_my_nxt     = r_move_y;
    w_mp_nxt     = r_move_p;
    w_player_nxt = r_player;
    w_acc_nxt    = 1'b0;
    w_rej_nxt    = 1'b0;

    case (r_state)
      S_COLLECT_X, S_COLLECT_Y: begin
        if (w_pa) begin
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_COLLECT_X;
        end else if (w_bit_valid) begin
          if (r_state == S_COLLECT_X) begin
            w_x_nxt = {r_x_sr[COORD_W-2:0], w_p1};
          end else begin
            w_y_nxt = {r_y_sr[COORD_W-2:0], w_p1};
          end
          if (r_cnt == c_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == S_COLLECT_X) ? S_COLLECT_Y : S_ARMED;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      S_ARMED: begin
        if (w_pa) begin
          if (w_legal) begin
            w_mx_nxt    = r_x_sr;
            w_my_nxt    = r_y_sr;
            w_mp_nxt    = r_player;
            w_state_nxt = S_OFFER;
          end else begin
            w_rej_nxt   = 1'b1;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_COLLECT_X;
          end
        end
      end

      S_OFFER: begin
        if (move_ready) begin
          w_state_nxt = S_WAIT_RESULT;
        end
      end

      S_WAIT_RESULT: begin
        if (result_valid) begin
          if (result_ok) begin
            w_player_nxt = player_t'(~r_player);
            w_acc_nxt    = 1'b1;
          end else begin
            w_rej_nxt = 1'b1;
          end
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_COLLECT_X;
        end
      end

      default: begin
        w_state_nxt = S_COLLECT_X;
      end
    endcase
  end

  assign move_valid    = (r_state == S_OFFER);
  assign move_x        = r_move_x;
  assign move_y        = r_move_y;
  assign move_player   = r_move_p;
  assign move_accepted = r_acc;
  assign move_rejected = r_rej;
  assign entry_phase   = phase_of(r_state);
  assign entry_value   = {r_x_sr, r_y_sr};

endmodule
`default_nettype wire
